// File: rtl/carry_bypass_pipe_if.sv
// carry_bypass_pipe_if
//   Groups the operand-side and result-side handshakes of carry_bypass_pipe.
//   Signals:
//     in_valid / in_ready   operand handshake (A, B, Cin, Sub travel with it)
//     out_valid / out_ready result handshake (S, Cout, Ovf travel with it)
//   Modports:
//     master : the side that supplies operands and consumes results
//     slave  : the adder pipeline itself
interface carry_bypass_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, Cout, Ovf
  );
endinterface

// File: rtl/carry_bypass_pipe.sv
// carry_bypass_pipe
//   Pipelined carry-bypass adder/subtractor. The WIDTH-bit operands are cut
//   into BLK-bit blocks; BPS blocks are evaluated per stage and the carry
//   between groups is registered, so the pipeline is L = WIDTH/BLK/BPS deep.
//   Full valid/ready back-pressure; stalled stages hold, bubbles compress.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     in_valid/in_ready/A/B/Cin/Sub, out_valid/out_ready/S/Cout/Ovf
//   bypass_cnt      (only with CARRY_BYPASS_STATS_EN) saturating count of
//                   bypassed blocks over all accepted results
// Optional feature macro: CARRY_BYPASS_STATS_EN
module carry_bypass_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8,
  parameter int BPS   = 1
) (
  input logic               clk,
  input logic               rst,
  carry_bypass_pipe_if.slave bus
`ifdef CARRY_BYPASS_STATS_EN
  ,
  output logic [31:0]       bypass_cnt
`endif
);
  localparam int NBLK = WIDTH / BLK;
  localparam int L    = NBLK / BPS;
  localparam int CW   = $clog2(NBLK + 1);

  if ((WIDTH % BLK) != 0 || (NBLK % BPS) != 0) begin : g_bad_param
    $error("carry_bypass_pipe: WIDTH must be a multiple of BLK*BPS");
  end

  // Running state of one operation as it walks down the pipe.
  typedef struct packed {
    logic [WIDTH-1:0] sum;  // sum bits of the groups processed so far
    logic             c;    // carry into the next group
    logic             cm;   // carry into the MSB, for overflow
    logic [CW-1:0]    pc;   // number of blocks whose carry was bypassed
  } acc_t;

  // Evaluate group g (blocks g*BPS .. g*BPS+BPS-1) on top of acc_in.
  function automatic acc_t grp_eval(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input acc_t             acc_in,
                                    input int               g);
    acc_t r;
    logic rc;
    logic x;
    logic p;
    int   bi;
    r = acc_in;
    for (int j = 0; j < BPS; j++) begin
      rc = r.c;
      p  = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        bi = (g * BPS + j) * BLK + i;
        x  = a[bi] ^ b[bi];
        r.sum[bi] = x ^ rc;
        if (bi == WIDTH - 1) r.cm = rc;
        rc = (a[bi] & b[bi]) | (x & rc);
        p  = p & x;
      end
      // When every bit propagates, the block's carry-in skips the ripple.
      r.c  = p ? r.c : rc;
      r.pc = r.pc + CW'(p);
    end
    return r;
  endfunction

  logic [L-1:0]     v_q;
  logic [L-1:0]     adv;
  logic             rdy_chain;
  acc_t             acc_q [L];
  acc_t             acc_d [L];
  acc_t             acc_in0;
  logic [WIDTH-1:0] a_q   [L];
  logic [WIDTH-1:0] b_q   [L];
  logic [WIDTH-1:0] beff;
  logic             c0;

  assign beff = bus.Sub ? ~bus.B : bus.B;
  assign c0   = bus.Sub | bus.Cin;

  // adv[k] = !v[k] | adv[k+1], flattened so it does not feed back on itself.
  always_comb begin
    adv       = '0;
    rdy_chain = bus.out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      rdy_chain = rdy_chain | ~v_q[k];
      adv[k]    = rdy_chain;
    end
  end

  always_comb begin
    acc_in0   = '0;
    acc_in0.c = c0;
  end

  always_comb begin
    acc_d[0] = grp_eval(bus.A, beff, acc_in0, 0);
    for (int k = 1; k < L; k++) begin
      acc_d[k] = grp_eval(a_q[k-1], b_q[k-1], acc_q[k-1], k);
    end
  end

  // Stage boundary: valid bits (the only reset state of the pipe)
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      if (adv[0]) v_q[0] <= bus.in_valid;
      for (int k = 1; k < L; k++) begin
        if (adv[k]) v_q[k] <= v_q[k-1];
      end
    end
  end

  // Stage boundary: data, held whenever the stage cannot advance
  always_ff @(posedge clk) begin
    if (adv[0]) begin
      acc_q[0] <= acc_d[0];
      a_q[0]   <= bus.A;
      b_q[0]   <= beff;
    end
    for (int k = 1; k < L; k++) begin
      if (adv[k]) begin
        acc_q[k] <= acc_d[k];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v_q[L-1];
  assign bus.S         = v_q[L-1] ? acc_q[L-1].sum : '0;
  assign bus.Cout      = v_q[L-1] & acc_q[L-1].c;
  assign bus.Ovf       = v_q[L-1] & (acc_q[L-1].c ^ acc_q[L-1].cm);

  // Operand copies in the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[L-1], b_q[L-1]};

`ifdef CARRY_BYPASS_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0]   x,
                                          input logic [CW-1:0] d);
    logic [32:0] s;
    s = {1'b0, x} + 33'(d);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (v_q[L-1] & bus.out_ready) begin
      cnt_q <= sat_add(cnt_q, acc_q[L-1].pc);
    end
  end

  assign bypass_cnt = cnt_q;
`else
  logic unused_pc;
  assign unused_pc = ^acc_q[L-1].pc;
`endif
endmodule

// File: tb/tb_carry_bypass_pipe.sv
module tb_carry_bypass_pipe;
  localparam int L0 = 4;
  localparam int L1 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carry_bypass_pipe_if #(.WIDTH(32)) b0 ();
  carry_bypass_pipe_if #(.WIDTH(64)) b1 ();

`ifdef CARRY_BYPASS_STATS_EN
  logic [31:0] cnt0;
  logic [31:0] cnt1;
`endif

  carry_bypass_pipe #(.WIDTH(32), .BLK(8), .BPS(1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
`ifdef CARRY_BYPASS_STATS_EN
    , .bypass_cnt (cnt0)
`endif
  );

  carry_bypass_pipe #(.WIDTH(64), .BLK(4), .BPS(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
`ifdef CARRY_BYPASS_STATS_EN
    , .bypass_cnt (cnt1)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result {Ovf, Cout, S} for a w-bit add/sub.
  function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub, input int w);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] beff;
    logic [64:0] full;
    logic        c0;
    logic        ov;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    beff = (sub ? ~b : b) & mask;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, am} + {1'b0, beff} + 65'(c0);
    ov   = (am[w-1] == beff[w-1]) && (full[w-1] != am[w-1]);
    return {ov, full[w], full[63:0] & mask};
  endfunction

  // Number of blk-bit blocks of a w-bit operation where every bit propagates.
  function automatic int pcount(input logic [63:0] a, input logic [63:0] b,
                                input logic sub, input int w, input int blk);
    logic [63:0] x;
    logic [63:0] m;
    int          n;
    n = 0;
    x = a ^ (sub ? ~b : b);
    m = (64'd1 << blk) - 64'd1;
    for (int j = 0; j < w / blk; j++) begin
      if (((x >> (j * blk)) & m) == m) n++;
    end
    return n;
  endfunction

  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  // One isolated operation on the 32-bit pipe with hand-computed results.
  task automatic op0(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic sub, input logic [31:0] es,
                     input logic ec, input logic eo, input int ep);
    int n;
    b0.A = a; b0.B = b; b0.Cin = cin; b0.Sub = sub;
    b0.in_valid = 1'b1; b0.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(b0.in_ready), 64'(1));
    tick();
    b0.in_valid = 1'b0;
    n = 0;
    while (!b0.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(L0 - 1));
    chk({tag, "_S"}, 64'(b0.S), 64'(es));
    chk({tag, "_Cout"}, 64'(b0.Cout), 64'(ec));
    chk({tag, "_Ovf"}, 64'(b0.Ovf), 64'(eo));
    tick();
    chk({tag, "_drained"}, 64'(b0.out_valid), 64'(0));
    exp_cnt0 += ep;
`ifdef CARRY_BYPASS_STATS_EN
    chk({tag, "_bypass_cnt"}, 64'(cnt0), 64'(exp_cnt0));
`endif
  endtask

  // Streaming / reset / random-run state
  logic [31:0] sa [10];
  logic [31:0] sb [10];
  logic        ss [10];
  logic        sc [10];
  logic [65:0] sexp [10];
  logic [65:0] q_exp [$];
  int          q_cyc [$];
  logic [65:0] e;
  logic        ordy;
  logic        was_held;
  logic        saw_full;
  logic        in_fire;
  logic        out_fire;
  logic        pending;
  logic [63:0] ra;
  logic [63:0] rb;
  logic        rsub;
  logic        rcin;
  int          sent;
  int          rcvd;
  int          occ;
  int          nv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    b0.in_valid = 1'b0; b0.A = '0; b0.B = '0; b0.Cin = 1'b0; b0.Sub = 1'b0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.A = '0; b1.B = '0; b1.Cin = 1'b0; b1.Sub = 1'b0; b1.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(b0.out_valid), 64'(0));
    chk("rst_S", 64'(b0.S), 64'(0));
    chk("rst_Cout", 64'(b0.Cout), 64'(0));
    chk("rst_Ovf", 64'(b0.Ovf), 64'(0));
    chk("rst_in_ready", 64'(b0.in_ready), 64'(1));
    chk("rst_in_ready_w64", 64'(b1.in_ready), 64'(1));
    chk("rst_out_valid_w64", 64'(b1.out_valid), 64'(0));
`ifdef CARRY_BYPASS_STATS_EN
    chk("rst_bypass_cnt", 64'(cnt0), 64'(0));
`endif

    // Directed vectors
    op0("all_bypass", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4);
    op0("sovf",       32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 2);
    op0("sub_neg",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 3);
    op0("sub_pos",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 3);

    // Streaming with out_ready pattern 1,0,0,1
    for (int i = 0; i < 10; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
      ss[i] = (i % 3 == 0); sc[i] = 1'($urandom % 2);
      sexp[i] = ref_op(64'(sa[i]), 64'(sb[i]), sc[i], ss[i], 32);
    end
    sent = 0; rcvd = 0; occ = 0; was_held = 1'b0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
      ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
      b0.out_ready = ordy;
      b0.in_valid  = (sent < 10);
      if (sent < 10) begin
        b0.A = sa[sent]; b0.B = sb[sent]; b0.Cin = sc[sent]; b0.Sub = ss[sent];
      end
      #1;
      chk("stream_in_ready", 64'(b0.in_ready), 64'((occ < L0) || ordy));
      if (occ == L0 && !ordy) saw_full = 1'b1;
      if (was_held) chk("stream_stall_valid", 64'(b0.out_valid), 64'(1));
      if (b0.out_valid && rcvd < 10) begin
        chk("stream_S", 64'(b0.S), 64'(sexp[rcvd][31:0]));
        chk("stream_OvfCout", 64'({b0.Ovf, b0.Cout}), 64'(sexp[rcvd][65:64]));
      end
      was_held = b0.out_valid && !ordy;
      in_fire  = b0.in_valid && b0.in_ready;
      out_fire = b0.out_valid && ordy;
      if (out_fire) begin
        exp_cnt0 += pcount(64'(sa[rcvd]), 64'(sb[rcvd]), ss[rcvd], 32, 8);
        rcvd++;
      end
      if (in_fire) sent++;
      occ = occ + int'(in_fire) - int'(out_fire);
      tick();
    end
    b0.in_valid = 1'b0;
    chk("stream_count", 64'(rcvd), 64'(10));
    chk("stream_full_seen", 64'(saw_full), 64'(1));
`ifdef CARRY_BYPASS_STATS_EN
    chk("stream_bypass_cnt", 64'(cnt0), 64'(exp_cnt0));
`endif

    // Reset mid-flight
    b0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b0.A = 32'hFFFF_FFFF; b0.B = 32'(i); b0.Cin = 1'b0; b0.Sub = 1'b0;
      b0.in_valid = 1'b1;
      #1;
      chk("midrst_in_ready", 64'(b0.in_ready), 64'(1));
      tick();
    end
    b0.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt0 = 0;
    chk("midrst_out_valid", 64'(b0.out_valid), 64'(0));
`ifdef CARRY_BYPASS_STATS_EN
    chk("midrst_bypass_cnt", 64'(cnt0), 64'(0));
`endif
    b0.out_ready = 1'b1;
    nv = 0;
    repeat (10) begin
      tick();
      if (b0.out_valid) nv++;
    end
    chk("midrst_no_stale", 64'(nv), 64'(0));
    op0("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0);

    // WIDTH=64, BLK=4, BPS=2: random add/sub stream
    b1.out_ready = 1'b1;
    sent = 0; rcvd = 0; pending = 1'b0;
    ra = '0; rb = '0; rsub = 1'b0; rcin = 1'b0;
    for (int cyc = 0; cyc < 3000 && rcvd < 1000; cyc++) begin
      if (!pending && sent < 1000 && ($urandom % 4 != 0)) begin
        ra   = {$urandom, $urandom};
        rsub = 1'($urandom % 2);
        rcin = 1'($urandom % 2);
        rb   = {$urandom, $urandom};
        if ($urandom % 8 == 0) rb = rsub ? ra : ~ra;
        pending = 1'b1;
      end
      b1.in_valid = pending;
      b1.A = ra; b1.B = rb; b1.Sub = rsub; b1.Cin = rcin;
      #1;
      if (b1.out_valid) begin
        chk("w64_queue_nonempty", 64'(q_exp.size() != 0), 64'(1));
        if (q_exp.size() != 0) begin
          e = q_exp.pop_front();
          chk("w64_S", b1.S, e[63:0]);
          chk("w64_OvfCout", 64'({b1.Ovf, b1.Cout}), 64'(e[65:64]));
          chk("w64_latency", 64'(cyc - q_cyc.pop_front()), 64'(L1));
          rcvd++;
        end
      end
      if (b1.in_valid && b1.in_ready) begin
        q_exp.push_back(ref_op(ra, rb, rcin, rsub, 64));
        q_cyc.push_back(cyc);
        exp_cnt1 += pcount(ra, rb, rsub, 64, 4);
        pending = 1'b0;
        sent++;
      end
      tick();
    end
    b1.in_valid = 1'b0;
    chk("w64_count", 64'(rcvd), 64'(1000));
`ifdef CARRY_BYPASS_STATS_EN
    chk("w64_bypass_cnt", 64'(cnt1), 64'(exp_cnt1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
